// File: rtl/mmio_responder_if.sv
// Data-port bus shared with the data memory: address, write data/strobes in,
// registered read data and window-hit flag out.
interface mmio_responder_if;
    logic [7:0]  access_address;
    logic [31:0] data_write;
    logic [3:0]  byte_enable;
    logic        write_enable;
    logic [31:0] data_read;
    logic        read_hit;

    modport master (
        output access_address, data_write, byte_enable, write_enable,
        input  data_read, read_hit
    );

    modport slave (
        input  access_address, data_write, byte_enable, write_enable,
        output data_read, read_hit
    );
endinterface

// File: rtl/mmio_responder.sv
// Memory-mapped responder: scratch registers, LED register, prescaled down-counting
// timer with interrupt flag and a read-only ID word in a 32-byte window.
module mmio_responder #(
    parameter logic [7:0]  BASE     = 8'hE0,
    parameter int unsigned PRESCALE = 1000,
    parameter logic [31:0] ID_VALUE = 32'h0B17_0001
) (
    input  logic                clk,
    input  logic                reset,
    mmio_responder_if.slave     bus,
    output logic [13:0]         led_out,
    output logic                irq
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] scratch0_q, scratch0_d;
    logic [31:0] scratch1_q, scratch1_d;
    logic [13:0] led_q, led_d;
    logic        reload_q, reload_d;
    logic        ie_q, ie_d;
    logic        flag_q, flag_d;
    logic [15:0] load_q, load_d;
    logic [15:0] count_q, count_d;
    logic [15:0] ps_q, ps_d;

    logic        hit;
    logic [2:0]  off;
    logic        wr;
    logic        ctrl_wr;
    logic        tick;
    logic [31:0] rd_val;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        unused_addr_lsb;

    assign wd      = bus.data_write;
    assign be      = bus.byte_enable;
    assign hit     = (bus.access_address[7:5] == BASE[7:5]);
    assign off     = bus.access_address[4:2];
    assign wr      = hit & bus.write_enable;
    assign ctrl_wr = wr && (off == 3'd3) && be[0];
    assign tick    = (state_q == RUN) && (ps_q == PS_LAST);
    assign unused_addr_lsb = ^bus.access_address[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Read mux sees pre-write register values, giving read-before-write.
    always_comb begin
        rd_val = '0;
        case (off)
            3'd0: rd_val = scratch0_q;
            3'd1: rd_val = scratch1_q;
            3'd2: rd_val = {18'd0, led_q};
            3'd3: rd_val = {28'd0, flag_q, ie_q, reload_q, state_q == RUN};
            3'd4: rd_val = {16'd0, load_q};
            3'd5: rd_val = {16'd0, count_q};
            3'd6: rd_val = ID_VALUE;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        led_d      = led_q;
        reload_d   = reload_q;
        ie_d       = ie_q;
        flag_d     = flag_q;
        load_d     = load_q;
        count_d    = count_q;
        ps_d       = ps_q;

        if (wr) begin
            case (off)
                3'd0: scratch0_d = merge(scratch0_q, wd, be);
                3'd1: scratch1_d = merge(scratch1_q, wd, be);
                3'd2: begin
                    if (be[0]) led_d[7:0]  = wd[7:0];
                    if (be[1]) led_d[13:8] = wd[13:8];
                end
                3'd3: begin
                    if (be[0]) begin
                        reload_d = wd[1];
                        ie_d     = wd[2];
                        if (wd[3]) flag_d = 1'b0;
                    end
                end
                3'd4: begin
                    if (be[0]) load_d[7:0]  = wd[7:0];
                    if (be[1]) load_d[15:8] = wd[15:8];
                end
                default: ;
            endcase
        end

        // The en bit is the FSM state; a clearing write pre-empts a same-cycle tick,
        // and an en=1 write on expiry keeps the timer running with a fresh load.
        case (state_q)
            IDLE: begin
                if (ctrl_wr && wd[0]) begin
                    state_d = RUN;
                    count_d = load_q;
                    ps_d    = '0;
                end
            end
            RUN: begin
                if (ctrl_wr && !wd[0]) begin
                    state_d = IDLE;
                end else begin
                    ps_d = tick ? '0 : ps_q + 16'd1;
                    if (tick) begin
                        if (count_q != '0) begin
                            count_d = count_q - 16'd1;
                        end else begin
                            flag_d = 1'b1;
                            if (reload_q || (ctrl_wr && wd[0])) count_d = load_q;
                            else state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            scratch0_q    <= '0;
            scratch1_q    <= '0;
            led_q         <= '0;
            reload_q      <= 1'b0;
            ie_q          <= 1'b0;
            flag_q        <= 1'b0;
            load_q        <= '0;
            count_q       <= '0;
            ps_q          <= '0;
            bus.data_read <= '0;
            bus.read_hit  <= 1'b0;
            irq           <= 1'b0;
        end else begin
            state_q       <= state_d;
            scratch0_q    <= scratch0_d;
            scratch1_q    <= scratch1_d;
            led_q         <= led_d;
            reload_q      <= reload_d;
            ie_q          <= ie_d;
            flag_q        <= flag_d;
            load_q        <= load_d;
            count_q       <= count_d;
            ps_q          <= ps_d;
            bus.data_read <= hit ? rd_val : '0;
            bus.read_hit  <= hit;
            irq           <= flag_q & ie_q;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: a behavioural model queues the expected
// outputs per clock and an independent monitor compares them after each edge.
module tb_mmio_responder;

    localparam int P = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] led_out;
    logic        irq;

    mmio_responder_if bus();

    mmio_responder #(
        .BASE(8'hE0),
        .PRESCALE(P),
        .ID_VALUE(32'h0B17_0001)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .led_out(led_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        hit;
        logic [13:0] led;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state
    logic [31:0] m_s0, m_s1;
    logic [13:0] m_led;
    logic        m_reload, m_ie, m_flag, m_run;
    logic [15:0] m_load, m_count;
    int          m_ps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return m_s0;
            3'd1: return m_s1;
            3'd2: return {18'd0, m_led};
            3'd3: return {28'd0, m_flag, m_ie, m_reload, m_run};
            3'd4: return {16'd0, m_load};
            3'd5: return {16'd0, m_count};
            3'd6: return 32'h0B17_0001;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic expiry_next();
        return m_run && (((m_ps + 1) % P) == 0) && (m_count == 16'd0);
    endfunction

    task automatic model_reset();
        m_s0 = '0; m_s1 = '0; m_led = '0; m_reload = 0; m_ie = 0; m_flag = 0;
        m_run = 0; m_load = '0; m_count = '0; m_ps = 0;
    endtask

    task automatic model_step(input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic we);
        exp_t        e;
        logic        hit, wr, cw, old_reload;
        logic [2:0]  off;
        logic [15:0] old_load;
        logic [31:0] tmp;
        hit = (a[7:5] == 3'b111);
        off = a[4:2];
        e.rd  = hit ? m_read(off) : 32'd0;
        e.hit = hit;
        e.irq = m_flag & m_ie;
        old_reload = m_reload;
        old_load   = m_load;
        wr = hit && we;
        cw = wr && (off == 3'd3) && be[0];
        if (wr) begin
            case (off)
                3'd0: m_s0 = merge32(m_s0, d, be);
                3'd1: m_s1 = merge32(m_s1, d, be);
                3'd2: begin tmp = merge32({18'd0, m_led}, d, be) & 32'h3FFF; m_led = tmp[13:0]; end
                3'd3: if (be[0]) begin
                    m_reload = d[1];
                    m_ie = d[2];
                    if (d[3]) m_flag = 0;
                end
                3'd4: begin tmp = merge32({16'd0, m_load}, d, be) & 32'hFFFF; m_load = tmp[15:0]; end
                default: ;
            endcase
        end
        if (!m_run) begin
            if (cw && d[0]) begin
                m_run = 1; m_count = old_load; m_ps = 0;
            end
        end else if (cw && !d[0]) begin
            m_run = 0;
        end else begin
            m_ps = (m_ps + 1) % P;
            if (m_ps == 0) begin
                if (m_count != 0) m_count = m_count - 16'd1;
                else begin
                    m_flag = 1;
                    if (old_reload || (cw && d[0])) m_count = old_load;
                    else m_run = 0;
                end
            end
        end
        e.led = m_led;
        q.push_back(e);
    endtask

    task automatic cycle(input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic we);
        @(negedge clk);
        bus.access_address = a;
        bus.data_write     = d;
        bus.byte_enable    = be;
        bus.write_enable   = we;
        model_step(a, d, be, we);
    endtask

    function automatic logic [7:0] ra(input int off);
        return 8'hE0 + 8'(off * 4);
    endfunction

    task automatic rd(input int off);
        cycle(ra(off), $urandom, 4'hF, 1'b0);
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be);
        cycle(ra(off), d, be, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_read"}, bus.data_read, 32'd0);
        check({tag, "_read_hit"}, {31'd0, bus.read_hit}, 32'd0);
        check({tag, "_led_out"}, {18'd0, led_out}, 32'd0);
        check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        bus.access_address = 8'h00;
        bus.write_enable   = 1'b0;
        bus.byte_enable    = 4'h0;
        reset = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: one queued expectation per rising edge while out of reset
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && q.size() > 0) begin
                e = q.pop_front();
                check("data_read", bus.data_read, e.rd);
                check("read_hit", {31'd0, bus.read_hit}, {31'd0, e.hit});
                check("led_out", {18'd0, led_out}, {18'd0, e.led});
                check("irq", {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin
        bus.access_address = 8'h00;
        bus.data_write     = '0;
        bus.byte_enable    = '0;
        bus.write_enable   = 1'b0;
        model_reset();
        do_reset("por");

        // ID read, out-of-window read
        rd(6);
        cycle(8'h20, 32'd0, 4'h0, 1'b0);
        rd(6);

        // Byte-enable merge and read-before-write on SCRATCH0
        wr(0, 32'hDEADBEEF, 4'b1111);
        wr(0, 32'h00000055, 4'b0001);
        rd(0);
        wr(1, $urandom, 4'b0000);
        rd(1);
        wr(1, 32'hCAFEF00D, 4'b1010);
        rd(1);

        // LED width masking, writes to RO offsets
        wr(2, 32'hFFFFFFFF, 4'hF);
        rd(2);
        wr(5, 32'h0000FFFF, 4'hF);
        rd(5);
        wr(6, 32'h12345678, 4'hF);
        rd(6);
        wr(7, 32'hFFFFFFFF, 4'hF);
        rd(7);

        // One-shot: LOAD=3, en|ie
        wr(4, 32'h00000003, 4'b0011);
        wr(3, 32'h00000005, 4'hF);
        for (int k = 0; k < 14; k++) rd((k % 2 == 0) ? 5 : 3);

        // Auto-reload with LOAD=1; W1C on expiry cycle, then on a quiet cycle
        wr(3, 32'h00000008, 4'h1);
        wr(4, 32'h00000001, 4'b0011);
        wr(3, 32'h00000007, 4'h1);
        for (int k = 0; k < 20 && !expiry_next(); k++) rd(5);
        check("expiry_wait_a", {31'd0, expiry_next()}, 32'd1);
        wr(3, 32'h0000000F, 4'h1);
        rd(3);
        for (int k = 0; k < 20 && expiry_next(); k++) rd(5);
        wr(3, 32'h0000000F, 4'h1);
        rd(3);
        rd(3);
        for (int k = 0; k < 8; k++) rd(5);
        wr(3, 32'h00000004, 4'h1);
        for (int k = 0; k < 4; k++) rd(5);

        // Expiry with reload=0 coinciding with an en=1 write
        wr(4, 32'h00000002, 4'b0011);
        wr(3, 32'h0000000D, 4'h1);
        for (int k = 0; k < 20 && !expiry_next(); k++) rd(5);
        check("expiry_wait_b", {31'd0, expiry_next()}, 32'd1);
        wr(3, 32'h00000005, 4'h1);
        for (int k = 0; k < 6; k++) rd((k % 2 == 0) ? 3 : 5);

        // Reset mid-count
        wr(3, 32'h00000008, 4'h1);
        wr(4, 32'h00000005, 4'b0011);
        wr(3, 32'h00000005, 4'h1);
        for (int k = 0; k < 30 && m_count != 16'd2; k++) rd(5);
        check("count_wait", {16'd0, m_count}, 32'd2);
        do_reset("midcount");
        for (int k = 0; k < 8; k++) rd((k % 2 == 0) ? 5 : 3);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            logic [7:0]  a;
            logic [31:0] d;
            int          off;
            off = int'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) != 0) ? ra(off) : 8'($urandom);
            d = $urandom;
            if (a[7:5] == 3'b111 && a[4:2] == 3'd4) d = 32'($urandom_range(0, 3));
            if (a[7:5] == 3'b111 && a[4:2] == 3'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            cycle(a, d, 4'($urandom), ($urandom_range(0, 1) == 1));
        end

        @(negedge clk);
        bus.write_enable = 1'b0;
        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        #2;
        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
